// File: rtl/guess_controller_pkg.sv
// Shared types and constants for the guess controller: word geometry, letter codes, FSM states.
package guess_controller_pkg;

  localparam int unsigned NUM_ROWS = 6;
  localparam int unsigned WORD_LEN = 5;
  localparam int unsigned LETTER_W = 5;
  localparam int unsigned WORD_W   = WORD_LEN * LETTER_W;
  localparam int unsigned ROW_W    = 3;
  localparam int unsigned CUR_W    = 3;

  typedef logic [LETTER_W-1:0] letter_t;
  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [WORD_LEN-1:0] flags_t;
  typedef logic [ROW_W-1:0]    row_t;
  typedef logic [CUR_W-1:0]    cursor_t;

  localparam letter_t LETTER_BLANK = 5'd31;
  localparam letter_t LETTER_MAX   = 5'd25;
  localparam cursor_t CURSOR_FULL  = 3'd5;
  localparam row_t    LAST_ROW     = 3'(NUM_ROWS - 1);
  localparam flags_t  ALL_GREEN    = 5'h1F;

  typedef enum logic [2:0] {
    StIdle,
    StEdit,
    StCheck,
    StCommit,
    StWon,
    StLost
  } state_e;

  function automatic word_t blank_word();
    return {WORD_LEN{LETTER_BLANK}};
  endfunction

endpackage

// File: rtl/guess_controller_if.sv
// Keypad, checker and display signals of the guess controller, bundled with driver/DUT views.
interface guess_controller_if;
  import guess_controller_pkg::*;

  logic    new_game;
  word_t   chosen_word;
  logic    key_valid;
  letter_t key_code;
  logic    key_del;
  logic    key_enter;
  flags_t  greens_in;
  flags_t  yellows_in;
  word_t   guess_word;
  word_t   answer_word;
  cursor_t cursor;
  logic    row_we;
  row_t    row_idx;
  flags_t  row_greens;
  flags_t  row_yellows;
  logic    reject;
  logic    game_won;
  logic    game_lost;

  modport master (
    output new_game, chosen_word, key_valid, key_code, key_del, key_enter, greens_in, yellows_in,
    input  guess_word, answer_word, cursor, row_we, row_idx, row_greens, row_yellows, reject,
           game_won, game_lost
  );

  modport slave (
    input  new_game, chosen_word, key_valid, key_code, key_del, key_enter, greens_in, yellows_in,
    output guess_word, answer_word, cursor, row_we, row_idx, row_greens, row_yellows, reject,
           game_won, game_lost
  );

endinterface

// File: rtl/guess_controller_letter_buffer.sv
// Five-slot edit buffer with cursor: append a letter, backspace, or clear to all blanks.
module guess_controller_letter_buffer
  import guess_controller_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clear_i,
  input  logic    wr_i,
  input  letter_t wr_letter_i,
  input  logic    del_i,
  output word_t   word_o,
  output cursor_t cursor_o
);

  word_t   word_q, word_d;
  cursor_t cursor_q, cursor_d;

  // Full/empty guards live here so callers can strobe freely.
  always_comb begin
    word_d   = word_q;
    cursor_d = cursor_q;
    if (clear_i) begin
      word_d   = blank_word();
      cursor_d = '0;
    end else if (wr_i && (cursor_q < CURSOR_FULL)) begin
      word_d[LETTER_W*int'(cursor_q) +: LETTER_W] = wr_letter_i;
      cursor_d = cursor_q + 3'd1;
    end else if (del_i && (cursor_q != '0)) begin
      word_d[LETTER_W*(int'(cursor_q) - 1) +: LETTER_W] = LETTER_BLANK;
      cursor_d = cursor_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= blank_word();
      cursor_q <= '0;
    end else begin
      word_q   <= word_d;
      cursor_q <= cursor_d;
    end
  end

  assign word_o   = word_q;
  assign cursor_o = cursor_q;

endmodule

// File: rtl/guess_controller.sv
// Guess entry and game tracking: edits a guess, hands it to the colour checker,
// commits the scored row to the display and decides win/lose.
module guess_controller
  import guess_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  guess_controller_if.slave bus_io
);

  state_e  state_q, state_d;
  row_t    row_idx_q, row_idx_d;
  word_t   answer_q, answer_d;
  flags_t  greens_q, greens_d;
  flags_t  yellows_q, yellows_d;
  flags_t  row_greens_q, row_greens_d;
  flags_t  row_yellows_q, row_yellows_d;
  logic    reject_q, reject_d;

  logic    buf_clear;
  logic    buf_wr;
  logic    buf_del;
  word_t   guess;
  cursor_t cursor;

  guess_controller_letter_buffer u_letter_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (buf_clear),
    .wr_i        (buf_wr),
    .wr_letter_i (bus_io.key_code),
    .del_i       (buf_del),
    .word_o      (guess),
    .cursor_o    (cursor)
  );

  always_comb begin
    state_d       = state_q;
    row_idx_d     = row_idx_q;
    answer_d      = answer_q;
    greens_d      = greens_q;
    yellows_d     = yellows_q;
    row_greens_d  = row_greens_q;
    row_yellows_d = row_yellows_q;
    reject_d      = 1'b0;
    buf_clear     = 1'b0;
    buf_wr        = 1'b0;
    buf_del       = 1'b0;

    // new_game overrides everything, including keys arriving in the same cycle.
    if (bus_io.new_game) begin
      state_d   = StEdit;
      answer_d  = bus_io.chosen_word;
      row_idx_d = '0;
      buf_clear = 1'b1;
    end else begin
      case (state_q)
        StEdit: begin
          if (bus_io.key_enter) begin
            if (cursor == CURSOR_FULL) state_d = StCheck;
            else                       reject_d = 1'b1;
          end else if (bus_io.key_del) begin
            buf_del = 1'b1;
          end else if (bus_io.key_valid && (bus_io.key_code <= LETTER_MAX)) begin
            buf_wr = 1'b1;
          end
        end
        StCheck: begin
          greens_d  = bus_io.greens_in;
          yellows_d = bus_io.yellows_in;
          state_d   = StCommit;
        end
        StCommit: begin
          row_greens_d  = greens_q;
          row_yellows_d = yellows_q;
          if (greens_q == ALL_GREEN) begin
            state_d = StWon;
          end else if (row_idx_q == LAST_ROW) begin
            state_d = StLost;
          end else begin
            state_d   = StEdit;
            row_idx_d = row_idx_q + 3'd1;
            buf_clear = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      row_idx_q     <= '0;
      answer_q      <= '0;
      greens_q      <= '0;
      yellows_q     <= '0;
      row_greens_q  <= '0;
      row_yellows_q <= '0;
      reject_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_idx_q     <= row_idx_d;
      answer_q      <= answer_d;
      greens_q      <= greens_d;
      yellows_q     <= yellows_d;
      row_greens_q  <= row_greens_d;
      row_yellows_q <= row_yellows_d;
      reject_q      <= reject_d;
    end
  end

  // Row flags show the freshly checked result during COMMIT, the last commit otherwise.
  assign bus_io.guess_word  = guess;
  assign bus_io.answer_word = answer_q;
  assign bus_io.cursor      = cursor;
  assign bus_io.row_we      = (state_q == StCommit);
  assign bus_io.row_idx     = row_idx_q;
  assign bus_io.row_greens  = (state_q == StCommit) ? greens_q : row_greens_q;
  assign bus_io.row_yellows = (state_q == StCommit) ? yellows_q : row_yellows_q;
  assign bus_io.reject      = reject_q;
  assign bus_io.game_won    = (state_q == StWon);
  assign bus_io.game_lost   = (state_q == StLost);

endmodule

// File: tb/tb_guess_controller.sv
// Directed bench for guess_controller: entry, submit, win, loss, priorities, reset abort.
module tb_guess_controller;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  guess_controller_if bus ();

  guess_controller dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] LA = 5'd0,  LB = 5'd1,  LC = 5'd2,  LD = 5'd3, LE = 5'd4;
  localparam logic [4:0] LF = 5'd5,  LN = 5'd13, LR = 5'd17, BL = 5'd31;

  function automatic logic [24:0] mkword(input logic [4:0] l0, input logic [4:0] l1,
                                         input logic [4:0] l2, input logic [4:0] l3,
                                         input logic [4:0] l4);
    return {l4, l3, l2, l1, l0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_key(input logic [4:0] c);
    bus.key_valid = 1'b1;
    bus.key_code  = c;
    tick();
    bus.key_valid = 1'b0;
  endtask

  task automatic press_del();
    bus.key_del = 1'b1;
    tick();
    bus.key_del = 1'b0;
  endtask

  task automatic press_enter();
    bus.key_enter = 1'b1;
    tick();
    bus.key_enter = 1'b0;
  endtask

  task automatic start_game(input logic [24:0] w);
    bus.chosen_word = w;
    bus.new_game    = 1'b1;
    tick();
    bus.new_game    = 1'b0;
  endtask

  task automatic type_word(input logic [24:0] w);
    for (int i = 0; i < 5; i++) press_key(w[5*i +: 5]);
  endtask

  logic [24:0] crane, abcde, plant;

  initial begin
    total = 0;
    bad   = 0;
    crane = mkword(LC, LR, LA, LN, LE);
    abcde = mkword(LA, LB, LC, LD, LE);
    plant = mkword(5'd15, 5'd11, LA, LN, 5'd19);
    bus.new_game    = 1'b0;
    bus.chosen_word = '0;
    bus.key_valid   = 1'b0;
    bus.key_code    = '0;
    bus.key_del     = 1'b0;
    bus.key_enter   = 1'b0;
    bus.greens_in   = '0;
    bus.yellows_in  = '0;
    rst_n = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_guess",   32'(bus.guess_word), 32'h1FFFFFF);
    chk("rst_answer",  32'(bus.answer_word), 32'h0);
    chk("rst_cursor",  32'(bus.cursor), 32'h0);
    chk("rst_row_idx", 32'(bus.row_idx), 32'h0);
    chk("rst_row_we",  32'(bus.row_we), 32'h0);
    chk("rst_greens",  32'(bus.row_greens), 32'h0);
    chk("rst_reject",  32'(bus.reject), 32'h0);
    chk("rst_won",     32'(bus.game_won), 32'h0);
    chk("rst_lost",    32'(bus.game_lost), 32'h0);
    rst_n = 1'b1;
    tick();

    // Keys ignored in IDLE
    press_key(LA);
    chk("idle_key_cursor", 32'(bus.cursor), 32'h0);

    // 1: new game CRANE
    start_game(crane);
    chk("ng_answer", 32'(bus.answer_word), 32'(crane));
    chk("ng_guess",  32'(bus.guess_word), 32'h1FFFFFF);
    chk("ng_cursor", 32'(bus.cursor), 32'h0);

    // 2: winning guess
    type_word(crane);
    chk("win_guess",  32'(bus.guess_word), 32'(crane));
    chk("win_cursor", 32'(bus.cursor), 32'h5);
    bus.greens_in  = 5'h1F;
    bus.yellows_in = 5'h00;
    press_enter();
    chk("win_check_no_we", 32'(bus.row_we), 32'h0);
    tick();
    chk("win_row_we",   32'(bus.row_we), 32'h1);
    chk("win_row_idx",  32'(bus.row_idx), 32'h0);
    chk("win_row_grn",  32'(bus.row_greens), 32'h1F);
    chk("win_not_yet",  32'(bus.game_won), 32'h0);
    tick();
    chk("win_we_drop",  32'(bus.row_we), 32'h0);
    chk("win_won",      32'(bus.game_won), 32'h1);
    chk("win_grn_hold", 32'(bus.row_greens), 32'h1F);
    press_del();
    press_key(LB);
    chk("won_keys_ign", 32'(bus.guess_word), 32'(crane));

    // 3: editing, reject, overflow, out-of-range code
    start_game(crane);
    chk("ng2_won_clr", 32'(bus.game_won), 32'h0);
    press_key(LA);
    press_key(LB);
    chk("ed_cursor2", 32'(bus.cursor), 32'h2);
    press_del();
    chk("ed_del_cursor", 32'(bus.cursor), 32'h1);
    chk("ed_del_guess",  32'(bus.guess_word), 32'(mkword(LA, BL, BL, BL, BL)));
    press_key(5'd27);
    chk("ed_code27", 32'(bus.cursor), 32'h1);
    press_enter();
    chk("ed_reject",     32'(bus.reject), 32'h1);
    tick();
    chk("ed_reject_end", 32'(bus.reject), 32'h0);
    chk("ed_rej_we",     32'(bus.row_we), 32'h0);
    press_key(LB);
    press_key(LC);
    press_key(LD);
    press_key(LE);
    chk("ed_full_cursor", 32'(bus.cursor), 32'h5);
    press_key(LF);
    chk("ed_6th_cursor", 32'(bus.cursor), 32'h5);
    chk("ed_6th_guess",  32'(bus.guess_word), 32'(abcde));

    // 4: six wrong guesses
    start_game(crane);
    bus.greens_in  = 5'h00;
    bus.yellows_in = 5'h0A;
    for (int r = 0; r < 6; r++) begin
      type_word(abcde);
      press_enter();
      tick();
      chk("lose_row_we",  32'(bus.row_we), 32'h1);
      chk("lose_row_idx", 32'(bus.row_idx), 32'(r));
      chk("lose_row_yel", 32'(bus.row_yellows), 32'h0A);
      tick();
      if (r < 5) begin
        chk("lose_next_cursor", 32'(bus.cursor), 32'h0);
        chk("lose_next_guess",  32'(bus.guess_word), 32'h1FFFFFF);
        chk("lose_next_idx",    32'(bus.row_idx), 32'(r + 1));
      end
    end
    chk("lose_lost",    32'(bus.game_lost), 32'h1);
    chk("lose_won",     32'(bus.game_won), 32'h0);
    chk("lose_idx_hold", 32'(bus.row_idx), 32'h5);
    press_del();
    press_enter();
    tick();
    chk("lost_keys_we",  32'(bus.row_we), 32'h0);
    chk("lost_keys_cur", 32'(bus.cursor), 32'h5);
    chk("lost_keys_idx", 32'(bus.row_idx), 32'h5);

    // 5: enter beats del/letter; new_game drops same-cycle key
    start_game(crane);
    chk("ng3_lost_clr", 32'(bus.game_lost), 32'h0);
    type_word(abcde);
    bus.key_valid = 1'b1;
    bus.key_code  = LF;
    bus.key_del   = 1'b1;
    bus.key_enter = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    bus.key_del   = 1'b0;
    bus.key_enter = 1'b0;
    chk("prio_cursor", 32'(bus.cursor), 32'h5);
    chk("prio_guess",  32'(bus.guess_word), 32'(abcde));
    tick();
    chk("prio_row_we", 32'(bus.row_we), 32'h1);
    tick();
    chk("prio_next_idx", 32'(bus.row_idx), 32'h1);
    bus.key_valid   = 1'b1;
    bus.key_code    = LD;
    start_game(plant);
    bus.key_valid   = 1'b0;
    chk("ngkey_cursor", 32'(bus.cursor), 32'h0);
    chk("ngkey_guess",  32'(bus.guess_word), 32'h1FFFFFF);
    chk("ngkey_idx",    32'(bus.row_idx), 32'h0);
    chk("ngkey_answer", 32'(bus.answer_word), 32'(plant));

    // 6: reset during CHECK aborts the commit
    bus.greens_in = 5'h1F;
    type_word(plant);
    press_enter();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_row_we", 32'(bus.row_we), 32'h0);
    chk("abort_guess",  32'(bus.guess_word), 32'h1FFFFFF);
    chk("abort_answer", 32'(bus.answer_word), 32'h0);
    chk("abort_cursor", 32'(bus.cursor), 32'h0);
    chk("abort_greens", 32'(bus.row_greens), 32'h0);
    tick();
    tick();
    chk("abort_hold_we", 32'(bus.row_we), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("abort_post_we",  32'(bus.row_we), 32'h0);
    tick();
    chk("abort_post_we2", 32'(bus.row_we), 32'h0);
    chk("abort_post_won", 32'(bus.game_won), 32'h0);
    chk("abort_post_idx", 32'(bus.row_idx), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends even if the sequence stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
